// File: rtl/kbd_port_fifo.sv
// Keyboard scancode FIFO behind a two-address CPU I/O port.
// Keyboard bytes are queued in a circular buffer. An F0 break prefix can be
// folded into bit 7 of the following byte. The CPU pops bytes from DATA_PORT
// and reads status from STAT_PORT. It writes STAT_PORT to set the interrupt
// enable and to flush the FIFO.
// Ports:
//   clock_cpu, reset_n       - clock, async active-low reset
//   port_address/read/write  - CPU I/O strobes and address
//   port_out                 - CPU write data
//   port_in                  - registered CPU read data (1-cycle latency)
//   port_ready               - always 1 outside reset
//   kb_hit/kb_data           - keyboard byte strobe and data
//   irq                      - registered interrupt level
module kbd_port_fifo #(
    parameter int unsigned DEPTH      = 16,
    parameter logic [15:0] DATA_PORT  = 16'h0060,
    parameter logic [15:0] STAT_PORT  = 16'h0064,
    parameter bit          FOLD_BREAK = 1'b1
) (
    input  logic        clock_cpu,
    input  logic        reset_n,
    input  logic [15:0] port_address,
    output logic [7:0]  port_in,
    input  logic [7:0]  port_out,
    input  logic        port_write,
    input  logic        port_read,
    output logic        port_ready,
    input  logic        kb_hit,
    input  logic [7:0]  kb_data,
    output logic        irq
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [7:0]  BREAK_PREFIX = 8'hF0;

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_brk;
    logic          r_ovf;
    logic          r_irq_en;
    logic [7:0]    r_last;
    logic [7:0]    r_port_in;
    logic          r_irq;
    logic          r_ready;

    logic [7:0] w_head;
    logic       w_empty;
    logic       w_full;
    logic       w_data_rd;
    logic       w_stat_rd;
    logic       w_stat_wr;
    logic       w_flush;
    logic       w_pop;
    logic       w_prefix;
    logic       w_push_req;
    logic [7:0] w_push_byte;
    logic       w_push;
    logic       w_drop;
    logic [3:0] w_count_sat;
    logic [7:0] w_status;
    logic       w_unused;

    // Only bits [1:0] of a status write carry meaning.
    assign w_unused = ^port_out[7:2];

    // Decode strobes, push/pop qualification and status byte.
    always_comb begin
        w_head      = r_mem[r_rd_ptr];
        w_empty     = (r_count == '0);
        w_full      = (r_count == CW'(DEPTH));
        w_data_rd   = port_read && (port_address == DATA_PORT);
        w_stat_rd   = port_read && (port_address == STAT_PORT);
        w_stat_wr   = port_write && (port_address == STAT_PORT);
        w_flush     = w_stat_wr && port_out[0];
        w_pop       = w_data_rd && !w_empty;
        w_prefix    = FOLD_BREAK && kb_hit && (kb_data == BREAK_PREFIX);
        w_push_req  = kb_hit && !w_prefix;
        w_push_byte = (FOLD_BREAK && r_brk) ? (kb_data | 8'h80) : kb_data;
        // A same-cycle pop frees the slot, so a full FIFO still accepts the byte.
        w_push      = w_push_req && !w_flush && (!w_full || w_pop);
        w_drop      = w_push_req && !w_flush && w_full && !w_pop;
        w_count_sat = (32'(r_count) > 32'd15) ? 4'hF : 4'(r_count);
        w_status    = {w_count_sat, r_brk, r_irq_en, r_ovf, !w_empty};
    end

    // Storage array; contents are meaningless outside [rd_ptr, wr_ptr).
    always_ff @(posedge clock_cpu) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_push_byte;
        end
    end

    // FIFO control, flags and registered port outputs.
    always_ff @(posedge clock_cpu or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_brk     <= 1'b0;
            r_ovf     <= 1'b0;
            r_irq_en  <= 1'b0;
            r_last    <= 8'hFF;
            r_port_in <= 8'hFF;
            r_irq     <= 1'b0;
            r_ready   <= 1'b1;
        end else begin
            r_ready <= 1'b1;
            r_irq   <= r_irq_en && !w_empty;

            if (w_stat_wr) begin
                r_irq_en <= port_out[1];
            end

            if (w_pop) begin
                r_last <= w_head;
            end

            if (port_read) begin
                if (w_data_rd) begin
                    r_port_in <= w_empty ? r_last : w_head;
                end else if (w_stat_rd) begin
                    r_port_in <= w_status;
                end else begin
                    r_port_in <= 8'hFF;
                end
            end

            if (w_flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
                r_brk    <= 1'b0;
                r_ovf    <= 1'b0;
            end else begin
                if (w_prefix) begin
                    r_brk <= 1'b1;
                end else if (w_push_req) begin
                    r_brk <= 1'b0;
                end

                // A fresh drop wins over the read-to-clear of the same cycle.
                if (w_drop) begin
                    r_ovf <= 1'b1;
                end else if (w_stat_rd) begin
                    r_ovf <= 1'b0;
                end

                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + AW'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + AW'(1);
                end
                if (w_push && !w_pop) begin
                    r_count <= r_count + CW'(1);
                end else if (w_pop && !w_push) begin
                    r_count <= r_count - CW'(1);
                end
            end
        end
    end

    assign port_in    = r_port_in;
    assign irq        = r_irq;
    assign port_ready = r_ready;

endmodule

// File: tb/tb_kbd_port_fifo.sv
module tb_kbd_port_fifo;

    localparam int unsigned DEPTH = 16;
    localparam logic [15:0] DP = 16'h0060;
    localparam logic [15:0] SP = 16'h0064;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] port_address;
    logic [7:0]  port_in;
    logic [7:0]  port_out;
    logic        port_write;
    logic        port_read;
    logic        port_ready;
    logic        kb_hit;
    logic [7:0]  kb_data;
    logic        irq;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [7:0] m_q[$];
    logic       m_brk, m_ovf, m_irq_en, m_irq;
    logic [7:0] m_last, m_port_in;

    always #5 clk = ~clk;

    kbd_port_fifo #(.DEPTH(DEPTH), .DATA_PORT(DP), .STAT_PORT(SP), .FOLD_BREAK(1'b1)) dut (
        .clock_cpu(clk), .reset_n(reset_n), .port_address(port_address),
        .port_in(port_in), .port_out(port_out), .port_write(port_write),
        .port_read(port_read), .port_ready(port_ready), .kb_hit(kb_hit),
        .kb_data(kb_data), .irq(irq)
    );

    function automatic logic [7:0] m_status();
        int c = m_q.size();
        logic [3:0] cs = (c > 15) ? 4'hF : 4'(c);
        return {cs, m_brk, m_irq_en, m_ovf, (c != 0)};
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_brk = 0; m_ovf = 0; m_irq_en = 0; m_irq = 0;
        m_last = 8'hFF; m_port_in = 8'hFF;
    endtask

    // Drive one cycle of stimulus, advance the model, sample 1ns after the edge.
    task automatic step(input logic hit, input logic [7:0] kd, input logic rd,
                        input logic wr, input logic [15:0] addr, input logic [7:0] wd);
        logic       push_req;
        logic [7:0] pbyte;
        logic       flush;
        kb_hit = hit; kb_data = kd; port_read = rd; port_write = wr;
        port_address = addr; port_out = wd;
        m_irq = m_irq_en && (m_q.size() != 0);
        if (rd) begin
            if (addr == DP) m_port_in = (m_q.size() != 0) ? m_q[0] : m_last;
            else if (addr == SP) m_port_in = m_status();
            else m_port_in = 8'hFF;
        end
        push_req = 0; pbyte = kd;
        flush = wr && (addr == SP) && wd[0];
        if (rd && addr == DP && m_q.size() != 0) m_last = m_q.pop_front();
        if (flush) begin
            m_q.delete(); m_ovf = 0; m_brk = 0;
        end else begin
            if (rd && addr == SP) m_ovf = 0;
            if (hit) begin
                if (kd == 8'hF0) m_brk = 1;
                else begin
                    push_req = 1;
                    pbyte = m_brk ? (kd | 8'h80) : kd;
                    m_brk = 0;
                end
            end
            if (push_req) begin
                if (m_q.size() < DEPTH) m_q.push_back(pbyte);
                else m_ovf = 1;
            end
        end
        if (wr && addr == SP) m_irq_en = wd[1];
        @(posedge clk); #1;
        kb_hit = 0; port_read = 0; port_write = 0;
    endtask

    task automatic do_reset();
        reset_n = 0;
        kb_hit = 0; kb_data = 0; port_read = 0; port_write = 0;
        port_address = 0; port_out = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++;
        if (port_in !== 8'hFF || irq !== 1'b0 || port_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_outputs got in=%h irq=%b rdy=%b exp in=ff irq=0 rdy=1", port_in, irq, port_ready);
        end
        reset_n = 1;
        @(posedge clk); #1;
        step(0, 0, 1, 0, SP, 0);
        n_tests++;
        if (port_in !== 8'h00) begin
            n_fail++; $display("FAIL reset_status got %h exp 00", port_in);
        end
        n_tests++;
        if (port_ready !== 1'b1) begin
            n_fail++; $display("FAIL ready_after_reset got %b exp 1", port_ready);
        end
    endtask

    task automatic test_basic();
        step(1, 8'h1C, 0, 0, 0, 0);
        step(1, 8'h32, 0, 0, 0, 0);
        step(0, 0, 1, 0, DP, 0);
        n_tests++;
        if (port_in !== 8'h1C) begin n_fail++; $display("FAIL basic_rd1 got %h exp 1c", port_in); end
        step(0, 0, 1, 0, DP, 0);
        n_tests++;
        if (port_in !== 8'h32) begin n_fail++; $display("FAIL basic_rd2 got %h exp 32", port_in); end
        step(0, 0, 1, 0, DP, 0);
        n_tests++;
        if (port_in !== 8'h32) begin n_fail++; $display("FAIL basic_rd_empty got %h exp 32", port_in); end
        step(0, 0, 0, 0, 0, 0);
        n_tests++;
        if (port_in !== 8'h32) begin n_fail++; $display("FAIL basic_hold got %h exp 32", port_in); end
        step(0, 0, 1, 0, SP, 0);
        n_tests++;
        if (port_in[0] !== 1'b0) begin n_fail++; $display("FAIL basic_status_empty got %h exp bit0=0", port_in); end
    endtask

    task automatic test_break();
        step(1, 8'hF0, 0, 0, 0, 0);
        step(0, 0, 1, 0, SP, 0);
        n_tests++;
        if (port_in !== 8'h08) begin n_fail++; $display("FAIL break_status got %h exp 08", port_in); end
        step(1, 8'h1C, 0, 0, 0, 0);
        step(0, 0, 1, 0, SP, 0);
        n_tests++;
        if (port_in !== 8'h11) begin n_fail++; $display("FAIL break_one_entry got %h exp 11", port_in); end
        step(0, 0, 1, 0, DP, 0);
        n_tests++;
        if (port_in !== 8'h9C) begin n_fail++; $display("FAIL break_fold got %h exp 9c", port_in); end
        step(1, 8'hE0, 0, 0, 0, 0);
        step(0, 0, 1, 0, DP, 0);
        n_tests++;
        if (port_in !== 8'hE0) begin n_fail++; $display("FAIL break_e0_raw got %h exp e0", port_in); end
    endtask

    task automatic test_overflow();
        logic [7:0] vals[$];
        for (int i = 0; i <= DEPTH; i++) begin
            logic [7:0] v = 8'(i * 7 + 3);
            vals.push_back(v);
            step(1, v, 0, 0, 0, 0);
        end
        step(0, 0, 1, 0, SP, 0);
        n_tests++;
        if (port_in !== 8'hF3) begin n_fail++; $display("FAIL ovf_status1 got %h exp f3", port_in); end
        step(0, 0, 1, 0, SP, 0);
        n_tests++;
        if (port_in !== 8'hF1) begin n_fail++; $display("FAIL ovf_status2 got %h exp f1", port_in); end
        for (int i = 0; i < DEPTH; i++) begin
            step(0, 0, 1, 0, DP, 0);
            n_tests++;
            if (port_in !== vals[i]) begin n_fail++; $display("FAIL ovf_drain%0d got %h exp %h", i, port_in, vals[i]); end
        end
        step(0, 0, 1, 0, DP, 0);
        n_tests++;
        if (port_in !== vals[DEPTH-1]) begin n_fail++; $display("FAIL ovf_extra_absent got %h exp %h", port_in, vals[DEPTH-1]); end
    endtask

    task automatic test_full_pushpop();
        for (int i = 0; i < DEPTH; i++) step(1, 8'(8'h20 + i), 0, 0, 0, 0);
        step(1, 8'h55, 1, 0, DP, 0);
        n_tests++;
        if (port_in !== 8'h20) begin n_fail++; $display("FAIL pp_head got %h exp 20", port_in); end
        step(0, 0, 1, 0, SP, 0);
        n_tests++;
        if (port_in !== 8'hF1) begin n_fail++; $display("FAIL pp_status got %h exp f1", port_in); end
        for (int i = 1; i <= DEPTH; i++) begin
            logic [7:0] e = (i == DEPTH) ? 8'h55 : 8'(8'h20 + i);
            step(0, 0, 1, 0, DP, 0);
            n_tests++;
            if (port_in !== e) begin n_fail++; $display("FAIL pp_drain%0d got %h exp %h", i, port_in, e); end
        end
    endtask

    task automatic test_irq();
        step(0, 0, 0, 1, SP, 8'h02);
        step(1, 8'hAA, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        n_tests++;
        if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_set got %b exp 1", irq); end
        step(0, 0, 1, 0, DP, 0);
        step(0, 0, 0, 0, 0, 0);
        n_tests++;
        if (irq !== 1'b0 || port_in !== 8'hAA) begin
            n_fail++; $display("FAIL irq_clear got irq=%b in=%h exp irq=0 in=aa", irq, port_in);
        end
        step(1, 8'h01, 0, 0, 0, 0);
        step(1, 8'h02, 0, 0, 0, 0);
        step(1, 8'h03, 0, 1, SP, 8'h01);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 0, SP, 0);
        n_tests++;
        if (port_in !== 8'h00 || irq !== 1'b0) begin
            n_fail++; $display("FAIL irq_flush got in=%h irq=%b exp in=00 irq=0", port_in, irq);
        end
    endtask

    task automatic test_bad_addr();
        step(1, 8'h11, 0, 0, 0, 0);
        step(0, 0, 0, 1, DP, 8'h03);
        step(0, 0, 1, 1, 16'h0061, 8'h03);
        n_tests++;
        if (port_in !== 8'hFF) begin n_fail++; $display("FAIL bad_addr_rd got %h exp ff", port_in); end
        step(0, 0, 1, 0, SP, 0);
        n_tests++;
        if (port_in !== 8'h11) begin n_fail++; $display("FAIL bad_addr_state got %h exp 11", port_in); end
        step(0, 0, 1, 0, DP, 0);
        n_tests++;
        if (port_in !== 8'h11) begin n_fail++; $display("FAIL bad_addr_data got %h exp 11", port_in); end
    endtask

    task automatic test_random();
        int errs = 0;
        for (int i = 0; i < 600; i++) begin
            logic        hit = ($urandom_range(0, 99) < 45);
            logic [7:0]  kd  = ($urandom_range(0, 5) == 0) ? 8'hF0 : 8'($urandom);
            logic        rd  = ($urandom_range(0, 99) < 30);
            logic        wr  = ($urandom_range(0, 99) < 4);
            int          sel = $urandom_range(0, 9);
            logic [15:0] a   = (sel < 6) ? DP : (sel < 9) ? SP : 16'h0070;
            logic [7:0]  wd  = {6'h0, 1'($urandom), ($urandom_range(0, 3) == 0)};
            if (wr) a = (sel < 8) ? SP : DP;
            step(hit, kd, rd, wr, a, wd);
            n_tests++;
            if (port_in !== m_port_in || irq !== m_irq) begin
                n_fail++;
                if (errs++ < 5)
                    $display("FAIL rand_cycle%0d got in=%h irq=%b exp in=%h irq=%b", i, port_in, irq, m_port_in, m_irq);
            end
        end
    endtask

    task automatic test_reset_mid();
        step(0, 0, 0, 1, SP, 8'h02);
        step(1, 8'h21, 0, 0, 0, 0);
        step(1, 8'h22, 0, 0, 0, 0);
        step(1, 8'h23, 1, 0, SP, 0);
        step(0, 0, 0, 0, 0, 0);
        #3 reset_n = 0;
        #1;
        n_tests++;
        if (port_in !== 8'hFF || irq !== 1'b0 || port_ready !== 1'b1) begin
            n_fail++; $display("FAIL midreset_out got in=%h irq=%b rdy=%b exp ff 0 1", port_in, irq, port_ready);
        end
        model_reset();
        @(posedge clk); #1;
        reset_n = 1;
        @(posedge clk); #1;
        step(0, 0, 1, 0, SP, 0);
        n_tests++;
        if (port_in !== 8'h00) begin n_fail++; $display("FAIL midreset_status got %h exp 00", port_in); end
        step(0, 0, 1, 0, DP, 0);
        n_tests++;
        if (port_in !== 8'hFF) begin n_fail++; $display("FAIL midreset_last got %h exp ff", port_in); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_break();
        test_overflow();
        test_full_pushpop();
        test_irq();
        test_bad_addr();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
